// File: rtl/sec_pkg.sv
// Shared types and widths for the background SEC scrubber.
// Data/check widths match the external 32-bit SEC corrector.
package sec_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_CHECK,
        S_WR_REQ,
        S_NEXT,
        S_GAP,
        S_DONE
    } scrub_state_t;

endpackage

// File: rtl/sec_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module sec_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sec_scrub_ctrl.sv
// Background scrubber: reads each word, runs it through the external
// SEC corrector and writes back words the corrector changed.
module sec_scrub_ctrl
    import sec_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int PAUSE  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              stop,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CHK_W-1:0]  mem_wchk,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [CHK_W-1:0]  mem_rchk,
    output logic [DATA_W-1:0] dec_d,
    output logic [CHK_W-1:0]  dec_c,
    output logic              dec_r,
    input  logic [DATA_W-1:0] dec_q,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  pass_cnt
);

    localparam int GAP_W    = (PAUSE > 1) ? $clog2(PAUSE) : 1;
    localparam int GAP_LAST = (PAUSE > 0) ? PAUSE - 1 : 0;
    localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_LAST);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(DEPTH - 1);

    scrub_state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dd_q, dd_d;
    logic [CHK_W-1:0]  dc_q, dc_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              cont_q, cont_d;

    logic launch;
    logic last_w;
    logic fixed;
    logic gap_end;
    logic clr_cnt;
    logic corr_en;

    assign launch  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
    assign last_w  = (addr_q == ADDR_END);
    assign fixed   = (dec_q != dd_q);
    assign gap_end = (gap_q == GAP_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (mem_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_rvalid) state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = fixed ? S_WR_REQ : S_NEXT;
            end
            S_WR_REQ: begin
                if (mem_gnt) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (stop) begin
                    state_d = S_DONE;
                end else if (!last_w) begin
                    state_d = S_RD_REQ;
                end else if (!cont_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = (PAUSE == 0) ? S_RD_REQ : S_GAP;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_DONE;
                end else if (gap_end) begin
                    state_d = S_RD_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
        mem_we  = (state_q == S_WR_REQ);
        dec_r   = (state_q == S_CHECK);
        done    = (state_q == S_DONE);
        busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    end

    always_comb begin
        addr_d  = addr_q;
        dd_d    = dd_q;
        dc_d    = dc_q;
        wd_d    = wd_q;
        pass_d  = pass_q;
        gap_d   = gap_q;
        cont_d  = cont_q;
        clr_cnt = 1'b0;
        corr_en = 1'b0;
        if (launch) begin
            addr_d  = '0;
            pass_d  = '0;
            cont_d  = cont;
            clr_cnt = 1'b1;
        end
        if ((state_q == S_RD_WAIT) && mem_rvalid) begin
            dd_d = mem_rdata;
            dc_d = mem_rchk;
        end
        if (state_q == S_CHECK) begin
            wd_d    = dec_q;
            corr_en = fixed;
        end
        if ((state_q == S_NEXT) && !stop) begin
            if (last_w) begin
                addr_d = '0;
                pass_d = pass_q + CNT_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (state_q == S_NEXT) gap_d = '0;
        if (state_q == S_GAP)  gap_d = gap_q + GAP_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            dd_q   <= '0;
            dc_q   <= '0;
            wd_q   <= '0;
            pass_q <= '0;
            gap_q  <= '0;
            cont_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            dd_q   <= dd_d;
            dc_q   <= dc_d;
            wd_q   <= wd_d;
            pass_q <= pass_d;
            gap_q  <= gap_d;
            cont_q <= cont_d;
        end
    end

    sec_sat_cnt #(
        .W (CNT_W)
    ) u_corr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_cnt),
        .en_i  (corr_en),
        .cnt_o (corr_cnt)
    );

    assign mem_addr  = addr_q;
    assign mem_wdata = wd_q;
    assign mem_wchk  = dc_q;
    assign dec_d     = dd_q;
    assign dec_c     = dc_q;
    assign pass_cnt  = pass_q;

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// Bench for sec_scrub_ctrl: memory responder, toy SEC corrector and
// a write scoreboard, driven by a vector table plus corner sequences.
module tb_sec_scrub_ctrl;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int PAUSE  = 3;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, cont, stop;
    logic              mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata, dec_d, dec_q;
    logic [7:0]        mem_wchk, mem_rchk, dec_c;
    logic              dec_r, busy, done;
    logic [CNT_W-1:0]  corr_cnt, pass_cnt;

    sec_scrub_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PAUSE  (PAUSE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .stop       (stop),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wchk   (mem_wchk),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rchk   (mem_rchk),
        .dec_d      (dec_d),
        .dec_c      (dec_c),
        .dec_r      (dec_r),
        .dec_q      (dec_q),
        .busy       (busy),
        .done       (done),
        .corr_cnt   (corr_cnt),
        .pass_cnt   (pass_cnt)
    );

    always #5 clk = ~clk;

    // Toy single-error code: check = XOR of (bit index + 1) over set bits.
    function automatic logic [7:0] code(input logic [31:0] d);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) if (d[i]) s = s ^ 6'(i + 1);
        return {2'b00, s};
    endfunction

    function automatic logic [31:0] fix(input logic [31:0] d, input logic [7:0] c);
        logic [5:0]  s;
        logic [31:0] r;
        s = c[5:0] ^ code(d);
        r = d;
        if (s != 0 && s <= 6'd32) r[s - 6'd1] = ~r[s - 6'd1];
        return r;
    endfunction

    always_comb begin
        dec_q = dec_d;
        if (dec_r) dec_q = fix(dec_d, dec_c);
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [7:0]        c;
    } wr_t;

    typedef struct packed {
        logic [3:0][31:0] data;
        logic [3:0][31:0] flip;
        logic [CNT_W-1:0] corr;
        logic [2:0]       nwr;
    } vec_t;

    logic [31:0] md [DEPTH];
    logic [7:0]  mc [DEPTH];
    wr_t         exp_wr[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_cnt, wr_cnt;
    int wr_dly = 0;
    int last3 = -1;
    int meas_gap = -1;
    logic [ADDR_W-1:0] exp_rd_addr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Memory responder: grants reads at once, writes after wr_dly cycles,
    // returns read data one cycle after the grant.
    initial begin
        logic              pend_rd, prev_pend;
        logic [ADDR_W-1:0] pend_a;
        logic [34+ADDR_W-1:0] prev;
        int                wcnt;
        wr_t               e;
        pend_rd = 0; prev_pend = 0; pend_a = '0; prev = '0; wcnt = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_rchk = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mem_gnt = 0;
            mem_rvalid = 0;
            if (rst) begin
                pend_rd = 0; prev_pend = 0; wcnt = 0;
                continue;
            end
            if (mem_req && prev_pend)
                chk("req_hold", {mem_we, mem_addr, mem_wdata, 1'b0}, prev);
            if (pend_rd) begin
                mem_rvalid = 1;
                mem_rdata = md[pend_a];
                mem_rchk = mc[pend_a];
                pend_rd = 0;
            end
            prev_pend = 0;
            if (mem_req) begin
                if (wcnt >= (mem_we ? wr_dly : 0)) begin
                    mem_gnt = 1;
                    wcnt = 0;
                    if (!mem_we) begin
                        chk("rd_addr", mem_addr, exp_rd_addr);
                        exp_rd_addr++;
                        rd_cnt++;
                        pend_rd = 1;
                        pend_a = mem_addr;
                        if (mem_addr == 3) last3 = cyc;
                        if (mem_addr == 0 && last3 >= 0) begin
                            meas_gap = cyc - last3;
                            last3 = -1;
                        end
                    end else begin
                        wr_cnt++;
                        if (exp_wr.size() == 0) begin
                            chk("wr_unexpected", 64'(mem_addr), 64'hFFFF);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", mem_addr, e.a);
                            chk("wr_data", mem_wdata, e.d);
                            chk("wr_chk", mem_wchk, e.c);
                        end
                        md[mem_addr] = mem_wdata;
                        mc[mem_addr] = mem_wchk;
                    end
                end else begin
                    wcnt++;
                    prev_pend = 1;
                    prev = {mem_we, mem_addr, mem_wdata, 1'b0};
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic c);
        exp_rd_addr = '0;
        last3 = -1;
        cont = c;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    task automatic load_clean();
        for (int w = 0; w < DEPTH; w++) begin
            md[w] = 32'h1234_5670 + 32'(w * 32'h0101_0101);
            mc[w] = code(md[w]);
        end
    endtask

    task automatic corrupt(input int w, input int b);
        exp_wr.push_back('{a: ADDR_W'(w), d: md[w], c: mc[w]});
        md[w][b] = ~md[w][b];
    endtask

    vec_t vt [4];

    initial begin
        int n;
        vt[0] = '{data: {32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h5555_AAAA},
                  flip: {32'h0, 32'h0, 32'h0, 32'h0}, corr: 2'd0, nwr: 3'd0};
        vt[1] = '{data: {32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 32'h5555_AAAA},
                  flip: {32'h0, 32'h1, 32'h0, 32'h0}, corr: 2'd1, nwr: 3'd1};
        vt[2] = '{data: {32'h0F0F_0F0F, 32'h1, 32'h8000_0000, 32'hCAFE_F00D},
                  flip: {32'h20, 32'h0, 32'h0, 32'h8000_0000}, corr: 2'd2, nwr: 3'd2};
        vt[3] = '{data: {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444},
                  flip: {32'h1, 32'h100, 32'h10000, 32'h1000000}, corr: 2'd3, nwr: 3'd4};

        rst = 1; start = 0; cont = 0; stop = 0;
        rd_cnt = 0; wr_cnt = 0;
        load_clean();
        tick();
        tick();
        chk("rst_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_corr", corr_cnt, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_decr", dec_r, 0);
        chk("rst_decd", dec_d, 0);
        rst = 0;
        tick();

        for (int v = 0; v < 4; v++) begin
            for (int w = 0; w < DEPTH; w++) begin
                md[w] = vt[v].data[w] ^ vt[v].flip[w];
                mc[w] = code(vt[v].data[w]);
                if (vt[v].flip[w] != 0)
                    exp_wr.push_back('{a: ADDR_W'(w), d: vt[v].data[w], c: mc[w]});
            end
            rd_cnt = 0;
            wr_cnt = 0;
            do_start(0);
            chk("vec_busy", busy, 1);
            wait_done(100, "vec_done");
            chk("vec_corr", corr_cnt, vt[v].corr);
            chk("vec_pass", pass_cnt, 1);
            chk("vec_reads", rd_cnt, DEPTH);
            chk("vec_writes", wr_cnt, vt[v].nwr);
            chk("vec_sb_empty", exp_wr.size(), 0);
            for (int w = 0; w < DEPTH; w++)
                chk("vec_mem", md[w], vt[v].data[w]);
        end

        // Continuous mode: gap length, start ignored while busy, stop in GAP.
        load_clean();
        rd_cnt = 0; wr_cnt = 0; meas_gap = -1;
        do_start(1);
        repeat (5) tick();
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (pass_cnt != 2 && n < 200) begin tick(); n++; end
        chk("cont_pass2", pass_cnt, 2);
        chk("cont_gap", meas_gap, 4 + PAUSE);
        stop = 1;
        tick();
        chk("stop_gap_done", done, 1);
        stop = 0;
        chk("cont_reads", rd_cnt, 2 * DEPTH);
        chk("cont_pass_hold", pass_cnt, 2);
        chk("cont_busy", busy, 0);

        // Saturation across passes: 4 errors, then one more injected in GAP.
        load_clean();
        rd_cnt = 0; wr_cnt = 0;
        for (int w = 0; w < DEPTH; w++) corrupt(w, 3 + w);
        do_start(1);
        n = 0;
        while (pass_cnt != 1 && n < 200) begin tick(); n++; end
        chk("sat_pass1", pass_cnt, 1);
        chk("sat_corr4", corr_cnt, 3);
        corrupt(1, 7);
        n = 0;
        while (pass_cnt != 2 && n < 200) begin tick(); n++; end
        stop = 1;
        wait_done(20, "sat_done");
        stop = 0;
        chk("sat_corr", corr_cnt, 3);
        chk("sat_writes", wr_cnt, 5);
        chk("sat_sb_empty", exp_wr.size(), 0);

        // Slow write grant with stop raised while the write is pending.
        load_clean();
        rd_cnt = 0; wr_cnt = 0;
        corrupt(1, 20);
        wr_dly = 5;
        do_start(0);
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin tick(); n++; end
        chk("slow_wr_seen", mem_req && mem_we, 1);
        stop = 1;
        tick();
        chk("slow_still_req", mem_req, 1);
        wait_done(40, "slow_done");
        stop = 0;
        wr_dly = 0;
        chk("slow_writes", wr_cnt, 1);
        chk("slow_reads", rd_cnt, 2);
        chk("slow_sb_empty", exp_wr.size(), 0);
        chk("slow_mem", md[1], 32'h1234_5670 + 32'h0101_0101);

        // Reset during a pending write, then a fresh scan from address 0.
        load_clean();
        rd_cnt = 0; wr_cnt = 0;
        corrupt(2, 0);
        wr_dly = 100;
        do_start(0);
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin tick(); n++; end
        chk("rst_wr_seen", mem_req && mem_we, 1);
        chk("rst_wr_corr", corr_cnt, 1);
        rst = 1;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_corr", corr_cnt, 0);
        chk("midrst_pass", pass_cnt, 0);
        exp_wr.delete();
        tick();
        rst = 0;
        wr_dly = 0;
        tick();
        exp_wr.push_back('{a: ADDR_W'(2), d: 32'h1234_5670 + 32'h0202_0202,
                           c: code(32'h1234_5670 + 32'h0202_0202)});
        rd_cnt = 0; wr_cnt = 0;
        do_start(0);
        wait_done(100, "rescan_done");
        chk("rescan_reads", rd_cnt, DEPTH);
        chk("rescan_writes", wr_cnt, 1);
        chk("rescan_corr", corr_cnt, 1);
        chk("rescan_sb_empty", exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
